cpu_bus_router: RTL and testbench

Parametrised read-path router between the CPU data/fetch bus and N memory-mapped slaves. It decodes the address against per-slave base/mask windows and enables exactly one slave. It supports variable-latency slaves through a per-slave ready handshake and stalls the CPU until data is valid. Unmapped addresses and slaves that never answer end with a bus error, and the failing address is captured for the exception handler.

---
 rtl/cpu_bus_router.sv | 146 ++++++++++++++
 tb/tb_cpu_bus_router.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_router.sv
// Read-path router between the CPU bus and N memory-mapped slaves: window decode,
// ready-handshake stalling, and bus-error reporting for unmapped or silent slaves.
module cpu_bus_router #(
    parameter int N_SLV   = 6,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter logic [N_SLV*ADDR_W-1:0] BASE = {32'h1FC08000, 32'h1FC09100, 32'h1FC09000,
                                               32'h1FE00000, 32'h1FC04000, 32'h1FC00000},
    parameter logic [N_SLV*ADDR_W-1:0] MASK = {32'h1FFFF000, 32'h1FFFFF00, 32'h1FFFFF00,
                                               32'h1FE00000, 32'h1FFFC000, 32'h1FFFC000},
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       addrBus,
    input  logic                    masterEN,
    output logic [DATA_W-1:0]       dataToCPU,
    output logic                    busStall,
    output logic                    busErr,
    output logic [ADDR_W-1:0]       errAddr,
    output logic [7:0]              errCnt,
    input  logic                    errClr,
    output logic [N_SLV-1:0]        slvEN,
    input  logic [N_SLV*DATA_W-1:0] slvData,
    input  logic [N_SLV-1:0]        slvReady
);

    localparam int IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, ERR} routerState;

    routerState          state, nextState;
    logic [N_SLV-1:0]    hit;
    logic                hitAny;
    logic [IDX_W-1:0]    hitIdx;
    logic [IDX_W-1:0]    sel;
    logic [ADDR_W-1:0]   reqAddr;
    logic [15:0]         waitCnt;
    logic                selReady;
    logic [DATA_W-1:0]   selData;
    logic                timedOut;

    always_comb begin
        for (int i = 0; i < N_SLV; i++) begin
            hit[i] = (addrBus & MASK[i*ADDR_W +: ADDR_W]) == BASE[i*ADDR_W +: ADDR_W];
        end
    end

    // Walk downwards so the lowest-indexed matching window is the one left standing.
    always_comb begin
        hitAny = |hit;
        hitIdx = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hitIdx = IDX_W'(i);
            end
        end
    end

    assign selReady = slvReady[sel];
    assign selData  = slvData[int'(sel)*DATA_W +: DATA_W];
    assign timedOut = (waitCnt == LAST_WAIT);

    // Outputs are gated by rst so a reset mid-transaction releases the bus at once.
    always_comb begin
        nextState = state;
        slvEN     = '0;
        busStall  = 1'b0;
        busErr    = 1'b0;
        dataToCPU = '0;
        case (state)
            IDLE: begin
                if (masterEN) begin
                    busStall = 1'b1;
                    if (hitAny) begin
                        slvEN[hitIdx] = 1'b1;
                        nextState     = WAIT;
                    end else begin
                        nextState = ERR;
                    end
                end
            end
            WAIT: begin
                slvEN[sel] = 1'b1;
                if (selReady) begin
                    dataToCPU = selData;
                    nextState = IDLE;
                end else if (timedOut) begin
                    busErr    = 1'b1;
                    nextState = IDLE;
                end else begin
                    busStall  = 1'b1;
                    dataToCPU = selData;
                end
            end
            ERR: begin
                busErr    = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
        if (rst) begin
            slvEN     = '0;
            busStall  = 1'b0;
            busErr    = 1'b0;
            dataToCPU = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sel     <= '0;
            reqAddr <= '0;
            waitCnt <= '0;
        end else begin
            state   <= nextState;
            waitCnt <= (state == WAIT) ? waitCnt + 16'd1 : 16'd0;
            if (state == IDLE && masterEN) begin
                reqAddr <= addrBus;
                if (hitAny) begin
                    sel <= hitIdx;
                end
            end
        end
    end

    // A clear wins over a simultaneous error so software never misses a reset of the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            errAddr <= '0;
            errCnt  <= '0;
        end else begin
            if (busErr) begin
                errAddr <= reqAddr;
            end
            if (errClr) begin
                errCnt <= '0;
            end else if (busErr && errCnt != 8'hFF) begin
                errCnt <= errCnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_bus_router.sv
// Bench for cpu_bus_router: a default-map instance and an overlapping-window, short-timeout
// instance share stimulus and are both compared every cycle against a transaction-level model.
module tb_cpu_bus_router;

    localparam int NS = 6;
    localparam logic [NS*32-1:0] BASE_DEF = {32'h1FC08000, 32'h1FC09100, 32'h1FC09000,
                                             32'h1FE00000, 32'h1FC04000, 32'h1FC00000};
    localparam logic [NS*32-1:0] MASK_DEF = {32'h1FFFF000, 32'h1FFFFF00, 32'h1FFFFF00,
                                             32'h1FE00000, 32'h1FFFC000, 32'h1FFFC000};
    localparam logic [NS*32-1:0] BASE_OV  = {32'h1FC08000, 32'h1FC09100, 32'h1FC09000,
                                             32'h1FE00000, 32'h1FC00000, 32'h1FC00000};

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             masterEN = 1'b0;
    logic             errClr = 1'b0;
    logic [31:0]      addrBus = '0;
    logic [NS*32-1:0] slvData = '0;
    logic [NS*32-1:0] dataStage = '0;
    logic [NS-1:0]    slvReady = '0;

    logic [NS-1:0]    enQ [2];
    logic             stallQ [2];
    logic             errQ [2];
    logic [31:0]      dataQ [2];
    logic [31:0]      errAddrQ [2];
    logic [7:0]       errCntQ [2];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cpu_bus_router dut (
        .clk(clk), .rst(rst), .addrBus(addrBus), .masterEN(masterEN),
        .dataToCPU(dataQ[0]), .busStall(stallQ[0]), .busErr(errQ[0]),
        .errAddr(errAddrQ[0]), .errCnt(errCntQ[0]), .errClr(errClr),
        .slvEN(enQ[0]), .slvData(slvData), .slvReady(slvReady)
    );

    cpu_bus_router #(.TIMEOUT(4), .BASE(BASE_OV), .MASK(MASK_DEF)) dutOv (
        .clk(clk), .rst(rst), .addrBus(addrBus), .masterEN(masterEN),
        .dataToCPU(dataQ[1]), .busStall(stallQ[1]), .busErr(errQ[1]),
        .errAddr(errAddrQ[1]), .errCnt(errCntQ[1]), .errClr(errClr),
        .slvEN(enQ[1]), .slvData(slvData), .slvReady(slvReady)
    );

    // Reference model: one outstanding transaction per instance, tracked as plain values.
    bit [31:0] mBase [2][NS];
    bit [31:0] mMask [2][NS];
    int        tmo [2];
    bit        busy [2], nBusy [2];
    bit        missing [2], nMiss [2];
    int        waited [2], nWaited [2];
    int        curSel [2], nSel [2];
    bit [31:0] curAddr [2], nAddr [2];
    bit [31:0] mErrAddr [2], nErrAddr [2];
    int        mErrCnt [2], nErrCnt [2];

    logic [NS-1:0] eEN;
    logic          eStall, eErr, errNow;
    logic [31:0]   eData;
    int            h;

    function automatic int hitIndex(input int k, input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if ((a & mMask[k][i]) == mBase[k][i]) return i;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic en, input logic [31:0] a,
                                 input logic [NS-1:0] rdy, input logic clr);
        @(posedge clk);
        #1;
        rst      = r;
        masterEN = en;
        addrBus  = a;
        slvReady = rdy;
        errClr   = clr;
        slvData  = dataStage;
        @(negedge clk);
    endtask

    always begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            eEN = '0; eStall = 1'b0; eErr = 1'b0; eData = '0; errNow = 1'b0;
            if (rst) begin
                busy[k] = 1'b0; missing[k] = 1'b0; waited[k] = 0;
                mErrAddr[k] = '0; mErrCnt[k] = 0;
            end
            nBusy[k] = busy[k]; nMiss[k] = missing[k]; nWaited[k] = waited[k];
            nSel[k] = curSel[k]; nAddr[k] = curAddr[k];
            if (rst) begin
                // everything held at zero
            end else if (missing[k]) begin
                eErr = 1'b1; errNow = 1'b1; nMiss[k] = 1'b0;
            end else if (busy[k]) begin
                eEN = 6'b000001 << curSel[k];
                if (slvReady[curSel[k]]) begin
                    eData = slvData[curSel[k]*32 +: 32];
                    nBusy[k] = 1'b0;
                end else if (waited[k] == tmo[k] - 1) begin
                    eErr = 1'b1; errNow = 1'b1; nBusy[k] = 1'b0;
                end else begin
                    eStall = 1'b1;
                    eData = slvData[curSel[k]*32 +: 32];
                    nWaited[k] = waited[k] + 1;
                end
            end else if (masterEN) begin
                eStall = 1'b1;
                nAddr[k] = addrBus;
                h = hitIndex(k, addrBus);
                if (h >= 0) begin
                    eEN = 6'b000001 << h;
                    nBusy[k] = 1'b1; nSel[k] = h; nWaited[k] = 0;
                end else begin
                    nMiss[k] = 1'b1;
                end
            end
            nErrAddr[k] = errNow ? curAddr[k] : mErrAddr[k];
            nErrCnt[k]  = errClr ? 0 : ((errNow && mErrCnt[k] < 255) ? mErrCnt[k] + 1 : mErrCnt[k]);
            if (rst) begin
                nErrAddr[k] = '0; nErrCnt[k] = 0;
            end
            checkOutput($sformatf("dut%0d.slvEN", k), 32'(enQ[k]), 32'(eEN));
            checkOutput($sformatf("dut%0d.busStall", k), 32'(stallQ[k]), 32'(eStall));
            checkOutput($sformatf("dut%0d.busErr", k), 32'(errQ[k]), 32'(eErr));
            checkOutput($sformatf("dut%0d.dataToCPU", k), dataQ[k], eData);
            checkOutput($sformatf("dut%0d.errAddr", k), errAddrQ[k], mErrAddr[k]);
            checkOutput($sformatf("dut%0d.errCnt", k), 32'(errCntQ[k]), 32'(mErrCnt[k]));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                busy[k] = 1'b0; missing[k] = 1'b0; waited[k] = 0;
                mErrAddr[k] = '0; mErrCnt[k] = 0;
            end else begin
                busy[k] = nBusy[k]; missing[k] = nMiss[k]; waited[k] = nWaited[k];
                curSel[k] = nSel[k]; curAddr[k] = nAddr[k];
                mErrAddr[k] = nErrAddr[k]; mErrCnt[k] = nErrCnt[k];
            end
        end
    end

    int          rPick;
    logic [31:0] rAddr;
    logic [NS-1:0] rRdy;

    initial begin
        for (int i = 0; i < NS; i++) begin
            mBase[0][i] = BASE_DEF[i*32 +: 32];
            mMask[0][i] = MASK_DEF[i*32 +: 32];
            mBase[1][i] = BASE_OV[i*32 +: 32];
            mMask[1][i] = MASK_DEF[i*32 +: 32];
        end
        tmo[0] = 255;
        tmo[1] = 4;
        for (int k = 0; k < 2; k++) begin
            busy[k] = 0; missing[k] = 0; waited[k] = 0; curSel[k] = 0;
            curAddr[k] = 0; mErrAddr[k] = 0; mErrCnt[k] = 0;
        end
        dataStage[0*32 +: 32] = 32'h12345678;
        dataStage[3*32 +: 32] = 32'h0BADBEEF;
        dataStage[4*32 +: 32] = 32'hCAFEF00D;
        #1 rst = 1'b1;

        // Reset values, with a live request on the bus that must not leak through.
        applyStimulus(1, 1, 32'h1FC00010, '0, 0);
        checkOutput("reset.slvEN", 32'(enQ[0]), 32'h0);
        checkOutput("reset.busStall", 32'(stallQ[0]), 32'h0);
        checkOutput("reset.busErr", 32'(errQ[0]), 32'h0);
        checkOutput("reset.dataToCPU", dataQ[0], 32'h0);
        checkOutput("reset.errAddr", errAddrQ[0], 32'h0);
        checkOutput("reset.errCnt", 32'(errCntQ[0]), 32'h0);
        applyStimulus(0, 0, 32'h0, '0, 0);

        // BIOS read, ready one cycle after enable; overlap instance must also pick slave 0.
        applyStimulus(0, 1, 32'h1FC00010, '0, 0);
        checkOutput("bios.c0.slvEN", 32'(enQ[0]), 32'h01);
        checkOutput("bios.c0.busStall", 32'(stallQ[0]), 32'h1);
        checkOutput("overlap.slvEN", 32'(enQ[1]), 32'h01);
        applyStimulus(0, 0, 32'h0, 6'b000001, 0);
        checkOutput("bios.c1.slvEN", 32'(enQ[0]), 32'h01);
        checkOutput("bios.c1.busStall", 32'(stallQ[0]), 32'h0);
        checkOutput("bios.c1.dataToCPU", dataQ[0], 32'h12345678);
        checkOutput("bios.c1.busErr", 32'(errQ[0]), 32'h0);
        applyStimulus(0, 0, 32'h0, '0, 0);
        checkOutput("bios.done.slvEN", 32'(enQ[0]), 32'h0);

        // SD ctrl, ready after 5 cycles, stray ready pulses from slave 0 in between.
        applyStimulus(0, 1, 32'h1FC09104, '0, 0);
        checkOutput("sd.c0.busStall", 32'(stallQ[0]), 32'h1);
        checkOutput("sd.c0.slvEN", 32'(enQ[0]), 32'h10);
        for (int c = 1; c < 5; c++) begin
            applyStimulus(0, 0, 32'h0, (c == 2 || c == 3) ? 6'b000001 : 6'b000000, 0);
            checkOutput($sformatf("sd.c%0d.busStall", c), 32'(stallQ[0]), 32'h1);
            checkOutput($sformatf("sd.c%0d.slvEN", c), 32'(enQ[0]), 32'h10);
        end
        applyStimulus(0, 0, 32'h0, 6'b010000, 0);
        checkOutput("sd.c5.busStall", 32'(stallQ[0]), 32'h0);
        checkOutput("sd.c5.dataToCPU", dataQ[0], 32'hCAFEF00D);

        // Unmapped address.
        applyStimulus(0, 1, 32'h00001000, '0, 0);
        checkOutput("miss.c0.slvEN", 32'(enQ[0]), 32'h0);
        checkOutput("miss.c0.busStall", 32'(stallQ[0]), 32'h1);
        applyStimulus(0, 0, 32'h0, '0, 0);
        checkOutput("miss.c1.busErr", 32'(errQ[0]), 32'h1);
        checkOutput("miss.c1.dataToCPU", dataQ[0], 32'h0);
        checkOutput("miss.c1.slvEN", 32'(enQ[0]), 32'h0);
        applyStimulus(0, 0, 32'h0, '0, 0);
        checkOutput("miss.errAddr", errAddrQ[0], 32'h00001000);
        checkOutput("miss.errCnt", 32'(errCntQ[0]), 32'h1);

        // GPIO with no ready: the TIMEOUT=4 instance errors in its 4th WAIT cycle.
        applyStimulus(0, 1, 32'h1FC09000, '0, 0);
        checkOutput("tmo.c0.busStall", 32'(stallQ[1]), 32'h1);
        checkOutput("tmo.c0.slvEN", 32'(enQ[1]), 32'h08);
        for (int c = 1; c < 4; c++) begin
            applyStimulus(0, 0, 32'h0, '0, 0);
            checkOutput($sformatf("tmo.c%0d.busStall", c), 32'(stallQ[1]), 32'h1);
            checkOutput($sformatf("tmo.c%0d.busErr", c), 32'(errQ[1]), 32'h0);
        end
        applyStimulus(0, 0, 32'h0, '0, 0);
        checkOutput("tmo.c4.busErr", 32'(errQ[1]), 32'h1);
        checkOutput("tmo.c4.busStall", 32'(stallQ[1]), 32'h0);
        checkOutput("tmo.c4.slvEN", 32'(enQ[1]), 32'h08);
        applyStimulus(0, 0, 32'h0, '0, 0);
        checkOutput("tmo.c5.slvEN", 32'(enQ[1]), 32'h0);
        checkOutput("tmo.c5.errCnt", 32'(errCntQ[1]), 32'h3);
        checkOutput("tmo.c5.errAddr", errAddrQ[1], 32'h1FC09000);
        checkOutput("wait.slvEN", 32'(enQ[0]), 32'h08);
        checkOutput("wait.busStall", 32'(stallQ[0]), 32'h1);

        // Asynchronous reset between edges while the default instance is still waiting.
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checkOutput("arst.slvEN", 32'(enQ[0]), 32'h0);
        checkOutput("arst.busStall", 32'(stallQ[0]), 32'h0);
        applyStimulus(1, 0, 32'h0, '0, 0);
        applyStimulus(0, 1, 32'h1FC00010, '0, 0);
        checkOutput("arst.next.slvEN", 32'(enQ[0]), 32'h01);
        checkOutput("arst.next.errCnt", 32'(errCntQ[0]), 32'h0);
        applyStimulus(0, 0, 32'h0, 6'b000001, 0);
        checkOutput("arst.next.dataToCPU", dataQ[0], 32'h12345678);

        // 300 back-to-back misses saturate the count; a clear alongside a miss wins.
        for (int c = 0; c < 600; c++) begin
            applyStimulus(0, 1, 32'h00001000, '0, 0);
        end
        applyStimulus(0, 0, 32'h0, '0, 0);
        applyStimulus(0, 0, 32'h0, '0, 0);
        checkOutput("sat.errCnt", 32'(errCntQ[0]), 32'd255);
        checkOutput("sat.ov.errCnt", 32'(errCntQ[1]), 32'd255);
        applyStimulus(0, 1, 32'h00001000, '0, 1);
        applyStimulus(0, 0, 32'h0, '0, 1);
        checkOutput("clr.busErr", 32'(errQ[0]), 32'h1);
        applyStimulus(0, 0, 32'h0, '0, 0);
        checkOutput("clr.errCnt", 32'(errCntQ[0]), 32'h0);
        checkOutput("clr.ov.errCnt", 32'(errCntQ[1]), 32'h0);

        // Randomized traffic, mostly aimed at real windows.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NS; i++) begin
                dataStage[i*32 +: 32] = $urandom;
                rRdy[i] = ($urandom_range(0, 3) == 0);
            end
            rPick = int'($urandom_range(0, 7));
            if (rPick < NS) rAddr = mBase[0][rPick] | ($urandom & ~mMask[0][rPick]);
            else            rAddr = $urandom;
            applyStimulus(($urandom_range(0, 499) == 0), 1'($urandom_range(0, 1)), rAddr, rRdy,
                          ($urandom_range(0, 31) == 0));
        end
        applyStimulus(0, 0, 32'h0, '0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
